jtag_bus_master: RTL and testbench
==================================

JTAG_BUS_MASTER -- requirements
Module: jtag_bus_master

Interface
REQ-001 The block SHALL have one parameter: ADDR_WIDTH, default 8, width of bus_addr and of the address register.
REQ-002 tck  input  1  the only clock; all state updates on its rising edge.
REQ-003 cpu_rstN  input  1  reset, asynchronous, active-low.
REQ-004 ir_in  input  3  virtual IR value from the SLD node.
REQ-005 tdi  input  1  JTAG serial data in.
REQ-006 vs_cdr, vs_sdr, vs_e1dr  input  1 each  virtual capture-DR, shift-DR and exit1-DR state flags, at most one high per cycle.
REQ-007 tdo  output  1  serial data out, equal to shift register bit 0.
REQ-008 ir_out  output  3  status back to the SLD node: {2'b00, partial}.
REQ-009 bus_addr  output  ADDR_WIDTH  current bus address, equal to the address register.
REQ-010 bus_wr  output  1  registered one-cycle write strobe.
REQ-011 bus_wdata  output  8  registered write data, valid while bus_wr=1.
REQ-012 bus_rd  output  1  combinational read strobe.
REQ-013 bus_rdata  input  8  slave read data, valid in the same cycle as bus_rd=1.

Function
REQ-014 IR decode SHALL be: 0=ADDR, 1=WRITE, 2=READ, 3=STATUS; codes 4-7 SHALL capture 0 and SHALL have no bus side effects.
REQ-015 Shift register (8b) on vs_cdr SHALL load: ADDR -> addr[7:0], zero-padded if ADDR_WIDTH<8; WRITE -> 0; READ -> bus_rdata; STATUS -> byte_cnt; other codes -> 0.
REQ-016 On vs_cdr, bit_cnt (3b) SHALL be cleared to 0.
REQ-017 On vs_sdr, shift register SHALL update as sr <= {tdi, sr[7:1]} and bit_cnt SHALL increment modulo 8, except where REQ-020 applies.
REQ-018 bus_rd SHALL equal (ir_in==2) AND (vs_cdr OR (vs_sdr AND bit_cnt==7)).
REQ-019 Each cycle with bus_rd=1: addr <= addr+1, wrapping modulo 2^ADDR_WIDTH, and byte_cnt <= byte_cnt+1, wrapping modulo 256.
REQ-020 READ, vs_sdr with bit_cnt==7: sr SHALL load bus_rdata (next-byte prefetch) instead of shifting.
REQ-021 Consequence of REQ-018 to REQ-020: a READ scan of N complete bytes issues N+1 reads and leaves addr = start+N+1.
REQ-022 WRITE, vs_sdr with bit_cnt==7: next edge bus_wr=1, bus_wdata={tdi, sr[7:1]}, bus_addr=current addr.
REQ-023 On the edge after bus_wr=1: bus_wr SHALL return to 0, addr SHALL increment with wrap, and byte_cnt SHALL increment.
REQ-024 bus_wr SHALL never be high for two consecutive cycles.
REQ-025 ADDR, vs_e1dr with bit_cnt==0 and at least one shift since capture: addr <= sr[ADDR_WIDTH-1:0], byte_cnt <= 0, partial <= 0.
REQ-026 ADDR, vs_e1dr with bit_cnt!=0: addr SHALL be unchanged.
REQ-027 ADDR scans longer than 8 bits SHALL use the last 8 bits shifted.
REQ-028 WRITE, vs_e1dr with bit_cnt!=0: the trailing partial byte SHALL be discarded, with no bus_wr, and partial SHALL be set to 1 (sticky).
REQ-029 A zero-length DR scan (vs_cdr then vs_e1dr) SHALL cause no write and no address change; the READ capture read of REQ-018 still occurs.
REQ-030 STATUS and codes 4-7 SHALL shift normally and SHALL NOT alter addr, byte_cnt or partial.

Reset
REQ-031 While cpu_rstN=0, outputs SHALL be asynchronously held at: sr=0, bit_cnt=0, addr=0, byte_cnt=0, partial=0, bus_wr=0, bus_wdata=0, tdo=0, ir_out=0.
REQ-032 bus_rd SHALL follow REQ-018 combinationally regardless of reset.
REQ-033 Reset asserted mid-scan SHALL abort any pending write, with no bus_wr after deassertion.
REQ-034 After reset deassertion, the next DR scan SHALL behave as if it were the first.

Verification
REQ-035 ADDR scan of 0x10 (8 bits), then WRITE scan of 0xA5,0x3C (16 bits) -> bus_wr pulses at addr 0x10 data 0xA5 and at 0x11 data 0x3C; final addr=0x12; STATUS reads 2.
REQ-036 ADDR 0x10, READ scan of 16 bits against a slave returning rdata=addr -> tdo bytes 0x10, 0x11; three bus_rd pulses; final addr=0x13.
REQ-037 ADDR 0xFF, WRITE 2 bytes -> writes at 0xFF, then 0x00 (wrap); ADDR 0xFF, READ 1 byte -> tdo byte 0xFF, addr wraps to 0x01.
REQ-038 WRITE scan of 12 bits -> exactly one bus_wr; ir_out=3'b001; a subsequent ADDR 8-bit scan clears ir_out to 0.
REQ-039 cpu_rstN pulsed low at bit 5 of a WRITE scan -> no bus_wr for that scan; addr=0; byte_cnt=0; the next 8-bit WRITE of 0x77 writes to address 0x00.
REQ-040 IR=5 scan of 8 bits -> tdo all 0; no bus_rd or bus_wr; addr and byte_cnt unchanged.

Source files
------------

// File: rtl/jtag_bus_master_if.sv
// jtag_bus_master_if
//   Bus-side connection between the JTAG bus master and a simple
//   byte-wide slave.
//
//   bus_addr   master -> slave  current bus address
//   bus_wr     master -> slave  one-cycle registered write strobe
//   bus_wdata  master -> slave  write data, valid while bus_wr=1
//   bus_rd     master -> slave  combinational read strobe
//   bus_rdata  slave -> master  read data, valid in the cycle bus_rd=1
interface jtag_bus_master_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_wr;
  logic [7:0]            bus_wdata;
  logic                  bus_rd;
  logic [7:0]            bus_rdata;

  modport master (
    output bus_addr, bus_wr, bus_wdata, bus_rd,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wr, bus_wdata, bus_rd,
    output bus_rdata
  );
endinterface

// File: rtl/jtag_bus_master.sv
// jtag_bus_master
//   Bridges a virtual JTAG (SLD) node to a byte-wide bus. The virtual IR
//   selects what a DR scan does: load the address register, stream write
//   bytes, stream read bytes (with prefetch), or report the byte count.
//
//   tck        in   the only clock
//   cpu_rstN   in   asynchronous active-low reset
//   ir_in      in   virtual IR value (0=ADDR 1=WRITE 2=READ 3=STATUS)
//   tdi        in   serial data in
//   vs_cdr     in   capture-DR state flag
//   vs_sdr     in   shift-DR state flag
//   vs_e1dr    in   exit1-DR state flag
//   tdo        out  serial data out (shift register bit 0)
//   ir_out     out  {2'b00, partial}; partial flags a discarded write byte
//   bus        master modport of jtag_bus_master_if
module jtag_bus_master #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  tck,
  input  logic                  cpu_rstN,
  input  logic [2:0]            ir_in,
  input  logic                  tdi,
  input  logic                  vs_cdr,
  input  logic                  vs_sdr,
  input  logic                  vs_e1dr,
  output logic                  tdo,
  output logic [2:0]            ir_out,
  jtag_bus_master_if.master     bus
);

  typedef enum logic [2:0] {
    IR_ADDR   = 3'd0,
    IR_WRITE  = 3'd1,
    IR_READ   = 3'd2,
    IR_STATUS = 3'd3
  } ir_e;

  // Wide enough for both the address and a byte, so the address can be
  // zero-padded into the shift register and the shift register zero-padded
  // into the address regardless of ADDR_WIDTH.
  localparam int XW = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

  logic [7:0]            sr_q, sr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic                  partial_q, partial_d;
  logic                  shifted_q, shifted_d;
  logic                  wr_q, wr_d;
  logic [7:0]            wdata_q, wdata_d;

  logic          is_addr, is_write, is_read, is_status;
  logic          last_bit;
  logic          rd;
  logic [1:0]    inc;
  logic [XW-1:0] addr_ext;
  logic [XW-1:0] sr_ext;

  assign is_addr   = (ir_in == IR_ADDR);
  assign is_write  = (ir_in == IR_WRITE);
  assign is_read   = (ir_in == IR_READ);
  assign is_status = (ir_in == IR_STATUS);
  assign last_bit  = (bit_cnt_q == 3'd7);

  // The read strobe fires at capture and again on the last bit of every
  // byte, so the next byte is already in hand when shifting resumes.
  // It is not gated by reset.
  assign rd = is_read && (vs_cdr || (vs_sdr && last_bit));

  assign addr_ext = XW'(addr_q);
  assign sr_ext   = XW'(sr_q);

  // A read and a completed write never coincide in a legal JTAG sequence,
  // but summing both keeps the address honest if they ever did.
  assign inc = {1'b0, rd} + {1'b0, wr_q};

  assign tdo           = sr_q[0];
  assign ir_out        = {2'b00, partial_q};
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_rd    = rd;

  // Next-state logic for the scan datapath and bus side effects.
  always_comb begin
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q + ADDR_WIDTH'(inc);
    byte_cnt_d = byte_cnt_q + 8'(inc);
    partial_d  = partial_q;
    shifted_d  = shifted_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;

    if (vs_cdr) begin
      bit_cnt_d = 3'd0;
      shifted_d = 1'b0;
      if (is_addr)        sr_d = addr_ext[7:0];
      else if (is_read)   sr_d = bus.bus_rdata;
      else if (is_status) sr_d = byte_cnt_q;
      else                sr_d = 8'd0;
    end else if (vs_sdr) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shifted_d = 1'b1;
      if (is_read && last_bit) sr_d = bus.bus_rdata;
      else                     sr_d = {tdi, sr_q[7:1]};
      if (is_write && last_bit) begin
        wr_d    = 1'b1;
        wdata_d = {tdi, sr_q[7:1]};
      end
    end else if (vs_e1dr) begin
      // Only a whole number of bytes (and at least one shift) loads the
      // address; the last byte shifted in is what ends up in sr.
      if (is_addr && (bit_cnt_q == 3'd0) && shifted_q) begin
        addr_d     = sr_ext[ADDR_WIDTH-1:0];
        byte_cnt_d = 8'd0;
        partial_d  = 1'b0;
      end
      if (is_write && (bit_cnt_q != 3'd0)) partial_d = 1'b1;
    end
  end

  // State registers; reset also drops any write queued for the next edge.
  always_ff @(posedge tck or negedge cpu_rstN) begin
    if (!cpu_rstN) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      partial_q  <= 1'b0;
      shifted_q  <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      partial_q  <= partial_d;
      shifted_q  <= shifted_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_jtag_bus_master.sv
// tb_jtag_bus_master
//   Directed bench for jtag_bus_master. Expected bus writes and read
//   addresses go into queues as scans are issued and are popped by a bus
//   monitor; scan results and registers are checked against a small model.
module tb_jtag_bus_master;

  logic       tck;
  logic       cpu_rstN;
  logic [2:0] ir_in;
  logic       tdi;
  logic       vs_cdr;
  logic       vs_sdr;
  logic       vs_e1dr;
  logic       tdo;
  logic [2:0] ir_out;

  jtag_bus_master_if #(.ADDR_WIDTH(8)) bus_if ();

  jtag_bus_master #(.ADDR_WIDTH(8)) dut (
    .tck      (tck),
    .cpu_rstN (cpu_rstN),
    .ir_in    (ir_in),
    .tdi      (tdi),
    .vs_cdr   (vs_cdr),
    .vs_sdr   (vs_sdr),
    .vs_e1dr  (vs_e1dr),
    .tdo      (tdo),
    .ir_out   (ir_out),
    .bus      (bus_if.master)
  );

  // Slave model: read data equals the address being read.
  assign bus_if.bus_rdata = bus_if.bus_addr;

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  int          rd_count = 0;
  logic        prev_wr = 1'b0;

  logic [7:0]  exp_addr = 8'd0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        exp_partial = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor, sampling mid-cycle.
  always @(negedge tck) begin
    logic [15:0] w;
    if (cpu_rstN) begin
      if (bus_if.bus_wr) begin
        checkOutput("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
        if (exp_wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 32'd1, 32'd0);
        end else begin
          w = exp_wr_q.pop_front();
          checkOutput("wr_addr", {24'd0, bus_if.bus_addr}, {24'd0, w[15:8]});
          checkOutput("wr_data", {24'd0, bus_if.bus_wdata}, {24'd0, w[7:0]});
        end
      end
      if (bus_if.bus_rd) begin
        rd_count++;
        if (exp_rd_q.size() == 0) begin
          checkOutput("rd_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("rd_addr", {24'd0, bus_if.bus_addr},
                      {24'd0, exp_rd_q.pop_front()});
        end
      end
      prev_wr = bus_if.bus_wr;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // One tck cycle: inputs change just after a rising edge, tdo is sampled
  // on the falling edge.
  task automatic applyStimulus(input logic cdr, input logic sdr,
                               input logic e1dr, input logic din,
                               output logic tdo_s);
    vs_cdr  = cdr;
    vs_sdr  = sdr;
    vs_e1dr = e1dr;
    tdi     = din;
    @(negedge tck);
    tdo_s = tdo;
    @(posedge tck);
    #1;
    vs_cdr  = 1'b0;
    vs_sdr  = 1'b0;
    vs_e1dr = 1'b0;
  endtask

  task automatic drScan(input logic [2:0] ir, input logic [31:0] data,
                        input int nbits, output logic [31:0] bits);
    logic b;
    bits  = '0;
    ir_in = ir;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, data[i], b);
      bits[i] = b;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, b);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, b);
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_addr"}, {24'd0, bus_if.bus_addr}, {24'd0, exp_addr});
    checkOutput({tag, "_ir_out"}, {29'd0, ir_out}, {31'd0, exp_partial});
    checkOutput({tag, "_wr_pending"}, exp_wr_q.size(), 32'd0);
    checkOutput({tag, "_rd_pending"}, exp_rd_q.size(), 32'd0);
  endtask

  task automatic scanAddr(input string tag, input logic [31:0] data,
                          input int nbits);
    logic [31:0] bits;
    drScan(3'd0, data, nbits, bits);
    if (nbits != 0 && nbits % 8 == 0) begin
      exp_addr    = 8'(data >> (nbits - 8));
      exp_cnt     = 8'd0;
      exp_partial = 1'b0;
    end
    checkRegs(tag);
  endtask

  task automatic scanWrite(input string tag, input logic [31:0] data,
                           input int nbits);
    logic [31:0] bits;
    for (int k = 0; k < nbits / 8; k++) begin
      exp_wr_q.push_back({exp_addr, data[8*k +: 8]});
      exp_addr = exp_addr + 8'd1;
      exp_cnt  = exp_cnt + 8'd1;
    end
    if (nbits % 8 != 0) exp_partial = 1'b1;
    drScan(3'd1, data, nbits, bits);
    checkRegs(tag);
  endtask

  task automatic scanRead(input string tag, input int nbytes);
    logic [31:0] bits;
    logic [31:0] exp_bits;
    logic [7:0]  a;
    int          rd_before;
    exp_bits = '0;
    a = exp_addr;
    for (int k = 0; k <= nbytes; k++) begin
      exp_rd_q.push_back(a);
      if (k < nbytes) exp_bits[8*k +: 8] = a;
      a = a + 8'd1;
    end
    rd_before = rd_count;
    drScan(3'd2, 32'd0, 8 * nbytes, bits);
    exp_addr = a;
    exp_cnt  = exp_cnt + 8'(nbytes + 1);
    checkOutput({tag, "_tdo"}, bits, exp_bits);
    checkOutput({tag, "_rd_count"}, rd_count - rd_before, nbytes + 1);
    checkRegs(tag);
  endtask

  task automatic scanStatus(input string tag);
    logic [31:0] bits;
    drScan(3'd3, 32'd0, 8, bits);
    checkOutput({tag, "_byte_cnt"}, bits, {24'd0, exp_cnt});
    checkRegs(tag);
  endtask

  initial begin
    logic [31:0] bits;
    logic        b;
    int          rd_before;

    cpu_rstN = 1'b0;
    ir_in    = 3'd0;
    tdi      = 1'b0;
    vs_cdr   = 1'b0;
    vs_sdr   = 1'b0;
    vs_e1dr  = 1'b0;
    $display("[TB] start");

    // Reset values, and bus_rd still live during reset.
    repeat (2) @(posedge tck);
    #1;
    checkOutput("rst_tdo", {31'd0, tdo}, 32'd0);
    checkOutput("rst_ir_out", {29'd0, ir_out}, 32'd0);
    checkOutput("rst_bus_wr", {31'd0, bus_if.bus_wr}, 32'd0);
    checkOutput("rst_bus_wdata", {24'd0, bus_if.bus_wdata}, 32'd0);
    checkOutput("rst_bus_addr", {24'd0, bus_if.bus_addr}, 32'd0);
    ir_in  = 3'd2;
    vs_cdr = 1'b1;
    #1;
    checkOutput("rst_bus_rd_comb", {31'd0, bus_if.bus_rd}, 32'd1);
    vs_cdr = 1'b0;
    ir_in  = 3'd0;
    #1;
    checkOutput("rst_bus_rd_idle", {31'd0, bus_if.bus_rd}, 32'd0);
    @(posedge tck);
    #1;
    cpu_rstN = 1'b1;
    @(posedge tck);
    #1;

    // Address then two-byte write, then status.
    scanAddr("addr10", 32'h10, 8);
    scanWrite("wr_a5_3c", 32'h3CA5, 16);
    scanStatus("status_2");

    // Two-byte read with prefetch.
    scanAddr("addr10_b", 32'h10, 8);
    scanRead("rd16", 2);

    // Wrap on write and on read.
    scanAddr("addrff", 32'hFF, 8);
    scanWrite("wr_wrap", 32'h3412, 16);
    scanAddr("addrff_b", 32'hFF, 8);
    scanRead("rd_wrap", 1);

    // Partial write byte, zero-length scans, short and long ADDR scans.
    scanAddr("addr50", 32'h50, 8);
    scanWrite("wr12", 32'hABC, 12);
    scanWrite("wr0", 32'h0, 0);
    scanAddr("addr_short", 32'h5, 4);
    scanAddr("addr_zero", 32'h0, 0);
    scanStatus("status_1");
    scanRead("rd0", 0);
    scanAddr("addr40", 32'h4099, 16);

    // Reset pulse in the middle of a write byte.
    scanAddr("addr20", 32'h20, 8);
    ir_in = 3'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, b);
    cpu_rstN = 1'b0;
    #2;
    checkOutput("midrst_addr", {24'd0, bus_if.bus_addr}, 32'd0);
    checkOutput("midrst_bus_wr", {31'd0, bus_if.bus_wr}, 32'd0);
    @(posedge tck);
    #1;
    cpu_rstN = 1'b1;
    exp_addr    = 8'd0;
    exp_cnt     = 8'd0;
    exp_partial = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, b);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, b);
    checkRegs("midrst");
    scanStatus("midrst_status");
    scanWrite("wr77", 32'h77, 8);

    // Unused IR code: captures zero, no bus traffic.
    scanAddr("addr33", 32'h33, 8);
    rd_before = rd_count;
    drScan(3'd5, 32'hFF, 8, bits);
    checkOutput("ir5_tdo", bits, 32'd0);
    checkOutput("ir5_rd_count", rd_count - rd_before, 32'd0);
    checkRegs("ir5");
    scanStatus("ir5_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
